// File: rtl/nco_disp_pkg.sv
// Shared constants and helpers for the NCO-driven BCD counter/display:
// 7-segment decode table, BCD limits and the per-digit carry/borrow step.
package nco_disp_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Segment patterns {a,b,c,d,e,f,g}, active-high; non-BCD codes go dark.
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h7E;
      4'd1:    s = 7'h30;
      4'd2:    s = 7'h6D;
      4'd3:    s = 7'h79;
      4'd4:    s = 7'h33;
      4'd5:    s = 7'h5B;
      4'd6:    s = 7'h5F;
      4'd7:    s = 7'h70;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h7B;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // One BCD digit step: {carry_out, digit}. cin is the carry (up) or borrow
  // (down) coming from the lower digit; with cin=0 the digit passes through.
  function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic up,
                                          input logic cin);
    logic [4:0] r;
    r = {1'b0, d};
    if (cin) begin
      if (up) begin
        r = (d >= BCD_MAX) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
      end else begin
        r = (d == 4'd0) ? {1'b1, BCD_MAX} : {1'b0, d - 4'd1};
      end
    end
    return r;
  endfunction

  // Saturate an arbitrary nibble into the BCD range.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/nco_tick.sv
// Numerically controlled tick generator: counts enabled cycles and flags the
// cycle in which the accumulator reaches the programmed period.
module nco_tick
  import nco_disp_pkg::*;
#(
  parameter int NCO_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [NCO_W-1:0] i_nco_num,
  output logic             o_tick_pre
);

  logic [NCO_W-1:0] acc_q, acc_d;
  logic             tick;

  // Tick on >= so a period lowered below the current phase fires at once;
  // the accumulator freezes while disabled to keep its phase.
  always_comb begin
    tick  = i_en && (i_nco_num != '0) && (acc_q >= (i_nco_num - NCO_W'(1)));
    acc_d = acc_q;
    if (i_en) begin
      if ((i_nco_num == '0) || tick) begin
        acc_d = '0;
      end else begin
        acc_d = acc_q + NCO_W'(1);
      end
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_tick_pre = tick;

endmodule

// File: rtl/nco_bcd_cnt_disp.sv
// NCO-clocked N-digit BCD up/down counter with load, driving a multiplexed
// 7-segment display with per-digit decimal points and optional
// leading-zero blanking.
module nco_bcd_cnt_disp
  import nco_disp_pkg::*;
#(
  parameter int NUM_DIGIT = 6,
  parameter int NCO_W     = 32,
  parameter int SCAN_DIV  = 50000,
  parameter int LZ_BLANK  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCO_W-1:0]       i_nco_num,
  input  logic                   i_en,
  input  logic                   i_up,
  input  logic                   i_load,
  input  logic [4*NUM_DIGIT-1:0] i_load_val,
  input  logic [NUM_DIGIT-1:0]   i_dp_mask,
  output logic [NUM_DIGIT-1:0]   o_seg_enb,
  output logic [6:0]             o_seg,
  output logic                   o_seg_dp,
  output logic [4*NUM_DIGIT-1:0] o_count,
  output logic                   o_tick,
  output logic                   o_wrap
);

  localparam int CNT_W  = 4 * NUM_DIGIT;
  localparam int IDX_W  = (NUM_DIGIT > 1) ? $clog2(NUM_DIGIT) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic                 tick_pre;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 tick_q, tick_d;
  logic                 wrap_q, wrap_d;
  logic                 carry;
  logic [4:0]           step;
  logic [SCAN_W-1:0]    scan_q, scan_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_DIGIT-1:0] seg_enb_q, seg_enb_d;
  logic [6:0]           seg_q, seg_d;
  logic                 seg_dp_q, seg_dp_d;
  logic [NUM_DIGIT-1:0] blank;
  logic                 all_zero;
  logic [3:0]           cur_digit;
  logic                 cur_blank;

  nco_tick #(
    .NCO_W(NCO_W)
  ) u_nco_tick (
    .clk       (clk),
    .rst       (rst),
    .i_en      (i_en),
    .i_nco_num (i_nco_num),
    .o_tick_pre(tick_pre)
  );

  // Counter next state: load beats a coincident tick; a tick ripples the
  // BCD carry/borrow from digit 0 upward and the final carry is the wrap.
  always_comb begin
    count_d = count_q;
    tick_d  = tick_pre;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    step    = '0;
    if (i_load) begin
      for (int k = 0; k < NUM_DIGIT; k++) begin
        count_d[4*k +: 4] = bcd_clamp(i_load_val[4*k +: 4]);
      end
    end else if (tick_pre) begin
      for (int k = 0; k < NUM_DIGIT; k++) begin
        step              = bcd_step(count_q[4*k +: 4], i_up, carry);
        count_d[4*k +: 4] = step[3:0];
        carry             = step[4];
      end
      wrap_d = carry;
    end
  end

  // Counter, tick and wrap registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  // Scan timing: dwell SCAN_DIV cycles per digit, then step the digit index.
  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_W'(NUM_DIGIT - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Scan counter and digit index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
    end
  end

  // Display next state: blanking walks down from the top digit while every
  // digit seen so far is zero; digit 0 always shows.
  always_comb begin
    all_zero  = 1'b1;
    blank     = '0;
    cur_digit = '0;
    cur_blank = 1'b0;
    seg_enb_d = '0;
    seg_dp_d  = 1'b0;
    for (int k = NUM_DIGIT - 1; k >= 0; k--) begin
      all_zero = all_zero & (count_q[4*k +: 4] == 4'd0);
      blank[k] = (LZ_BLANK != 0) && (k > 0) && all_zero;
    end
    for (int k = 0; k < NUM_DIGIT; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_digit    = count_q[4*k +: 4];
        cur_blank    = blank[k];
        seg_enb_d[k] = 1'b1;
        seg_dp_d     = i_dp_mask[k];
      end
    end
    seg_d = cur_blank ? 7'h00 : seg7_decode(cur_digit);
  end

  // Registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_enb_q <= '0;
      seg_q     <= '0;
      seg_dp_q  <= 1'b0;
    end else begin
      seg_enb_q <= seg_enb_d;
      seg_q     <= seg_d;
      seg_dp_q  <= seg_dp_d;
    end
  end

  assign o_seg_enb = seg_enb_q;
  assign o_seg     = seg_q;
  assign o_seg_dp  = seg_dp_q;
  assign o_count   = count_q;
  assign o_tick    = tick_q;
  assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_nco_bcd_cnt_disp.sv
// Bench for nco_bcd_cnt_disp: instance A (2 digits) exercises the NCO and
// counter against a decimal reference model through a scoreboard; instance
// B (4 digits, blanking on) exercises the display scanner.
module tb_nco_bcd_cnt_disp;

  logic        clk;
  int          checks   = 0;
  int          failures = 0;

  // Instance A stimulus / response
  logic        rst_a, en_a, up_a, load_a;
  logic [31:0] num_a;
  logic [7:0]  load_val_a;
  logic [1:0]  dp_a;
  logic [1:0]  o_seg_enb_a;
  logic [6:0]  o_seg_a;
  logic        o_seg_dp_a, o_tick_a, o_wrap_a;
  logic [7:0]  o_count_a;

  // Instance B stimulus / response
  logic        rst_b, en_b, up_b, load_b;
  logic [31:0] num_b;
  logic [15:0] load_val_b;
  logic [3:0]  dp_b;
  logic [3:0]  o_seg_enb_b;
  logic [6:0]  o_seg_b;
  logic        o_seg_dp_b, o_tick_b, o_wrap_b;
  logic [15:0] o_count_b;

  typedef struct packed {
    logic       tick;
    logic       wrap;
    logic [7:0] cnt;
  } exp_a_t;

  typedef struct packed {
    logic [3:0] enb;
    logic [6:0] seg;
    logic       dp;
  } exp_b_t;

  exp_a_t sb_a[$];
  exp_b_t sb_b[$];

  int m_acc = 0;
  int m_cnt = 0;

  nco_bcd_cnt_disp #(
    .NUM_DIGIT(2), .NCO_W(32), .SCAN_DIV(3), .LZ_BLANK(0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .i_nco_num(num_a), .i_en(en_a), .i_up(up_a),
    .i_load(load_a), .i_load_val(load_val_a), .i_dp_mask(dp_a),
    .o_seg_enb(o_seg_enb_a), .o_seg(o_seg_a), .o_seg_dp(o_seg_dp_a),
    .o_count(o_count_a), .o_tick(o_tick_a), .o_wrap(o_wrap_a)
  );

  nco_bcd_cnt_disp #(
    .NUM_DIGIT(4), .NCO_W(32), .SCAN_DIV(3), .LZ_BLANK(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .i_nco_num(num_b), .i_en(en_b), .i_up(up_b),
    .i_load(load_b), .i_load_val(load_val_b), .i_dp_mask(dp_b),
    .o_seg_enb(o_seg_enb_b), .o_seg(o_seg_b), .o_seg_dp(o_seg_dp_b),
    .o_count(o_count_b), .o_tick(o_tick_b), .o_wrap(o_wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp2int(input logic [7:0] v);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  // One clock of instance A: predict from the inputs now applied, push,
  // clock, then pop and compare against what the DUT presents.
  task automatic step_a();
    exp_a_t e, got;
    logic   tk;
    e = '0;
    if (rst_a) begin
      m_acc = 0;
      m_cnt = 0;
    end else begin
      tk     = en_a && (num_a != 0) && (m_acc >= int'(num_a) - 1);
      e.tick = tk;
      if (en_a) m_acc = ((num_a == 0) || tk) ? 0 : m_acc + 1;
      if (load_a) begin
        m_cnt = clamp2int(load_val_a);
      end else if (tk) begin
        if (up_a) begin
          e.wrap = (m_cnt == 99);
          m_cnt  = (m_cnt + 1) % 100;
        end else begin
          e.wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + 99) % 100;
        end
      end
    end
    e.cnt = int2bcd(m_cnt);
    sb_a.push_back(e);
    @(posedge clk);
    #1;
    got = sb_a.pop_front();
    check("a_tick",  32'(o_tick_a),  32'(got.tick));
    check("a_wrap",  32'(o_wrap_a),  32'(got.wrap));
    check("a_count", 32'(o_count_a), 32'(got.cnt));
  endtask

  task automatic run_a(input int n);
    for (int i = 0; i < n; i++) step_a();
  endtask

  // Lock onto the start of a scan frame on instance B and compare 12 cycles
  // (4 digits x 3 cycles) against the expected digit patterns.
  task automatic b_frame(input string tag, input logic [6:0] s0,
                         input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3);
    logic [3:0] prev;
    logic [3:0] one;
    logic [6:0] segs[4];
    bit         found;
    exp_b_t     e;
    one     = 4'b0001;
    segs[0] = s0;
    segs[1] = s1;
    segs[2] = s2;
    segs[3] = s3;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = o_seg_enb_b;
      @(posedge clk);
      #1;
      if ((prev != 4'b0001) && (o_seg_enb_b == 4'b0001)) found = 1'b1;
    end
    check({tag, "_sync"}, 32'(found), 32'd1);
    if (found) begin
      for (int d = 0; d < 4; d++) begin
        for (int r = 0; r < 3; r++) begin
          e.enb = one << d;
          e.seg = segs[d];
          e.dp  = dp_b[d];
          sb_b.push_back(e);
        end
      end
      for (int i = 0; i < 12; i++) begin
        if (i > 0) begin
          @(posedge clk);
          #1;
        end
        e = sb_b.pop_front();
        check({tag, "_enb"}, 32'(o_seg_enb_b), 32'(e.enb));
        check({tag, "_seg"}, 32'(o_seg_b),     32'(e.seg));
        check({tag, "_dp"},  32'(o_seg_dp_b),  32'(e.dp));
      end
    end
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0; up_a = 1'b1; load_a = 1'b0;
    num_a = 32'd4; load_val_a = 8'h00; dp_a = 2'b01;
    rst_b = 1'b1; en_b = 1'b0; up_b = 1'b1; load_b = 1'b0;
    num_b = 32'd4; load_val_b = 16'h0000; dp_b = 4'b0010;

    // Reset state of A
    step_a();
    check("a_rst_enb", 32'(o_seg_enb_a), 32'd0);
    check("a_rst_seg", 32'(o_seg_a),     32'd0);
    check("a_rst_dp",  32'(o_seg_dp_a),  32'd0);
    rst_a = 1'b0;

    // Free count up, period 4, through the 09->10 carry
    en_a = 1'b1;
    run_a(40);
    check("a_cnt40", 32'(o_count_a), 32'h10);

    // Load 98, three ticks: 99, 00 (wrap), 01
    load_a = 1'b1; load_val_a = 8'h98;
    step_a();
    load_a = 1'b0;
    run_a(12);
    check("a_up_wrap_01", 32'(o_count_a), 32'h01);

    // Load 00, count down one tick: 99 with wrap
    up_a = 1'b0; load_a = 1'b1; load_val_a = 8'h00;
    step_a();
    load_a = 1'b0;
    run_a(4);
    check("a_dn_99", 32'(o_count_a), 32'h99);

    // Pause with acc=2: no ticks, first tick two cycles after resume
    en_a = 1'b0;
    run_a(10);
    en_a = 1'b1;
    run_a(2);
    check("a_resume_tick", 32'(o_tick_a), 32'd1);

    // Nibble clamp on load
    load_a = 1'b1; load_val_a = 8'h1A;
    step_a();
    check("a_clamp", 32'(o_count_a), 32'h19);

    // Load coincident with a tick: load wins, no wrap; then wrap on next tick
    up_a = 1'b1; num_a = 32'd1; load_val_a = 8'h99;
    step_a();
    check("a_ldtick_cnt",  32'(o_count_a), 32'h99);
    check("a_ldtick_wrap", 32'(o_wrap_a),  32'd0);
    load_a = 1'b0;
    step_a();
    check("a_num1_wrap", 32'(o_wrap_a), 32'd1);
    run_a(4);

    // Period 0 halts ticking
    num_a = 32'd0;
    run_a(6);

    // Reset mid-count at 57
    num_a = 32'd4; load_a = 1'b1; load_val_a = 8'h57;
    step_a();
    load_a = 1'b0;
    run_a(2);
    rst_a = 1'b1;
    step_a();
    check("a_mrst_enb", 32'(o_seg_enb_a), 32'd0);
    check("a_mrst_seg", 32'(o_seg_a),     32'd0);
    check("a_mrst_dp",  32'(o_seg_dp_a),  32'd0);
    rst_a = 1'b0;
    run_a(10);

    // Instance B: reset state, then the scanner
    @(posedge clk);
    #1;
    check("b_rst_enb", 32'(o_seg_enb_b), 32'd0);
    check("b_rst_seg", 32'(o_seg_b),     32'd0);
    check("b_rst_cnt", 32'(o_count_b),   32'd0);
    rst_b = 1'b0;
    load_b = 1'b1; load_val_b = 16'h0042;
    @(posedge clk);
    #1;
    load_b = 1'b0;
    check("b_load", 32'(o_count_b), 32'h0042);
    b_frame("b42", 7'h6D, 7'h33, 7'h00, 7'h00);

    // All zero: digit 0 still shows, higher digits blank
    load_b = 1'b1; load_val_b = 16'h0000;
    @(posedge clk);
    #1;
    load_b = 1'b0;
    b_frame("b00", 7'h7E, 7'h00, 7'h00, 7'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
